// File: rtl/minmax_tracker_if.sv
// Purpose : stream bundle for minmax_tracker: sample input (valid/ready/data/last)
//           and per-frame result output (valid/ready/min/max/indices/count).
// Latency : none, wires only.
// Backpressure: carries in_ready/out_ready; slave = tracker, master = source/sink.
interface minmax_tracker_if #(
  parameter int N     = 8,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_min;
  logic [N-1:0]     out_max;
  logic [CNT_W-1:0] out_min_idx;
  logic [CNT_W-1:0] out_max_idx;
  logic [CNT_W-1:0] out_count;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_min, out_max, out_min_idx, out_max_idx, out_count
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_min, out_max, out_min_idx, out_max_idx, out_count
  );
endinterface

// File: rtl/minmax_tracker.sv
// Purpose : per-frame running min/max tracker with beat indices and saturating count.
//           Ports: clk, rst_n (sync, active-low), bus (minmax_tracker_if.slave).
//           Optional macro MINMAX_SIGNED_EN selects two's-complement ordering.
// Latency : result out_valid one cycle after the last beat is accepted.
// Backpressure: in_ready drops while a result is held; result held until out_ready.

// Recursive equal / less-than compare (a<b), unsigned. N must be a power of two.
module comparator #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         eq,
  output logic         lt
);
  generate
    if (N == 1) begin : g_leaf
      assign eq = (a[0] == b[0]);
      assign lt = ~a[0] & b[0];
    end else begin : g_split
      localparam int H = N / 2;
      logic eq_hi, lt_hi, eq_lo, lt_lo;

      comparator #(.N(H)) u_hi (.a(a[N-1:H]), .b(b[N-1:H]), .eq(eq_hi), .lt(lt_hi));
      comparator #(.N(H)) u_lo (.a(a[H-1:0]), .b(b[H-1:0]), .eq(eq_lo), .lt(lt_lo));

      // Upper half decides unless it is equal; then the lower half decides.
      assign eq = eq_hi & eq_lo;
      assign lt = lt_hi | (eq_hi & lt_lo);
    end
  endgenerate
endmodule

module minmax_tracker #(
  parameter int N     = 8,
  parameter int CNT_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  minmax_tracker_if.slave bus
);
  typedef enum logic [1:0] {
    S_FIRST = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             in_ready_int;
  logic             out_valid_int;
  logic             accept;

  logic [N-1:0]     min_q, max_q;
  logic [CNT_W-1:0] min_idx_q, max_idx_q, cnt_q;

  // Comparison keys: flipping the sign bit maps two's-complement order onto
  // unsigned order, so one unsigned comparator serves both modes.
  logic [N-1:0]     flip;
  logic [N-1:0]     key_new, key_min, key_max;
  logic             eq_min, lt_min, eq_max, lt_max;
  logic             upd_min, upd_max;

  always_comb begin
    flip = '0;
`ifdef MINMAX_SIGNED_EN
    flip[N-1] = 1'b1;
`else
    flip[N-1] = 1'b0;
`endif
  end

  assign key_new = bus.in_data ^ flip;
  assign key_min = min_q ^ flip;
  assign key_max = max_q ^ flip;

  comparator #(.N(N)) u_cmp_min (.a(key_new), .b(key_min), .eq(eq_min), .lt(lt_min));
  comparator #(.N(N)) u_cmp_max (.a(key_max), .b(key_new), .eq(eq_max), .lt(lt_max));

  // Strictly-less only: ties keep the earliest occurrence.
  assign upd_min = lt_min & ~eq_min;
  assign upd_max = lt_max & ~eq_max;

  assign accept = bus.in_valid & in_ready_int;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FIRST;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FIRST, S_ACCUM: begin
        if (accept) begin
          state_d = bus.in_last ? S_HOLD : S_ACCUM;
        end
      end
      S_HOLD: begin
        if (bus.out_ready) begin
          state_d = S_FIRST;
        end
      end
      default: state_d = S_FIRST;
    endcase
  end

  // Output decode: registered state only, so no in_valid -> out_valid path.
  always_comb begin
    in_ready_int  = 1'b0;
    out_valid_int = 1'b0;
    case (state_q)
      S_FIRST, S_ACCUM: in_ready_int  = rst_n;
      S_HOLD:           out_valid_int = 1'b1;
      default: begin
        in_ready_int  = 1'b0;
        out_valid_int = 1'b0;
      end
    endcase
  end

  // Running statistics; these registers are also the result outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      min_q     <= '0;
      max_q     <= '0;
      min_idx_q <= '0;
      max_idx_q <= '0;
      cnt_q     <= '0;
    end else if (accept) begin
      if (state_q == S_FIRST) begin
        min_q     <= bus.in_data;
        max_q     <= bus.in_data;
        min_idx_q <= '0;
        max_idx_q <= '0;
        cnt_q     <= {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        // cnt_q is this beat's index; once saturated it stays the index.
        if (upd_min) begin
          min_q     <= bus.in_data;
          min_idx_q <= cnt_q;
        end
        if (upd_max) begin
          max_q     <= bus.in_data;
          max_idx_q <= cnt_q;
        end
        if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign bus.in_ready    = in_ready_int;
  assign bus.out_valid   = out_valid_int;
  assign bus.out_min     = min_q;
  assign bus.out_max     = max_q;
  assign bus.out_min_idx = min_idx_q;
  assign bus.out_max_idx = max_idx_q;
  assign bus.out_count   = cnt_q;
endmodule

// File: tb/tb_minmax_tracker.sv
// Purpose : directed self-checking bench for minmax_tracker (CNT_W=8 and CNT_W=2 instances
//           fed the same stream); expectations follow MINMAX_SIGNED_EN when defined.
// Latency : results checked 1ns after the clock edge that accepts the last beat.
// Backpressure: out_ready is held low across several cycles while a beat is offered.
module tb_minmax_tracker;
  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  minmax_tracker_if #(.N(8), .CNT_W(8)) i8 ();
  minmax_tracker_if #(.N(8), .CNT_W(2)) i2 ();

  minmax_tracker #(.N(8), .CNT_W(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(i8));
  minmax_tracker #(.N(8), .CNT_W(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(i2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic l);
    i8.in_valid = v; i8.in_data = d; i8.in_last = l;
    i2.in_valid = v; i2.in_data = d; i2.in_last = l;
  endtask

  task automatic set_ordy(input logic r);
    i8.out_ready = r;
    i2.out_ready = r;
  endtask

  // Present one beat until accepted (bounded), then withdraw it.
  task automatic beat(input logic [7:0] d, input logic l);
    bit ok;
    ok = 1'b0;
    drive(1'b1, d, l);
    for (int i = 0; i < 20; i++) begin
      if (i8.in_ready) begin
        tick();
        ok = 1'b1;
        break;
      end
      tick();
    end
    drive(1'b0, 8'h00, 1'b0);
    chk("beat_accept_timeout", {31'd0, ok}, 32'd1);
  endtask

  task automatic chk_res(input string tag, input logic [7:0] mn, input logic [7:0] mni,
                         input logic [7:0] mx, input logic [7:0] mxi, input logic [7:0] cnt);
    chk({tag, "_valid"},   {31'd0, i8.out_valid},  32'd1);
    chk({tag, "_min"},     {24'd0, i8.out_min},     {24'd0, mn});
    chk({tag, "_min_idx"}, {24'd0, i8.out_min_idx}, {24'd0, mni});
    chk({tag, "_max"},     {24'd0, i8.out_max},     {24'd0, mx});
    chk({tag, "_max_idx"}, {24'd0, i8.out_max_idx}, {24'd0, mxi});
    chk({tag, "_count"},   {24'd0, i8.out_count},   {24'd0, cnt});
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    drive(1'b0, 8'h00, 1'b0);
    set_ordy(1'b0);
    tick(); tick();

    // Reset state
    chk("rst_in_ready",  {31'd0, i8.in_ready},  32'd0);
    chk("rst_out_valid", {31'd0, i8.out_valid}, 32'd0);
    chk("rst_min",       {24'd0, i8.out_min},   32'd0);
    chk("rst_max",       {24'd0, i8.out_max},   32'd0);
    chk("rst_count",     {24'd0, i8.out_count}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_in_ready", {31'd0, i8.in_ready}, 32'd1);

    // Frame 5,3,9,3,9 with out_ready high throughout
    set_ordy(1'b1);
    beat(8'd5, 1'b0);
    chk("accum_no_valid", {31'd0, i8.out_valid}, 32'd0);
    beat(8'd3, 1'b0);
    beat(8'd9, 1'b0);
    beat(8'd3, 1'b0);
    beat(8'd9, 1'b1);
    chk_res("f1", 8'd3, 8'd1, 8'd9, 8'd2, 8'd5);
    chk("f1_hold_in_ready", {31'd0, i8.in_ready}, 32'd0);
    tick();
    chk("f1_valid_dropped", {31'd0, i8.out_valid}, 32'd0);
    chk("f1_min_held",      {24'd0, i8.out_min},   32'd3);

    // Single-beat frame, result held until out_ready
    set_ordy(1'b0);
    beat(8'hA5, 1'b1);
    chk_res("single", 8'hA5, 8'd0, 8'hA5, 8'd0, 8'd1);
    drive(1'b1, 8'h11, 1'b0);
    tick();
    chk("single_hold_in_ready", {31'd0, i8.in_ready}, 32'd0);
    chk("single_hold_min",      {24'd0, i8.out_min},  32'hA5);
    set_ordy(1'b1);
    tick();
    chk("single_hs_valid",    {31'd0, i8.out_valid}, 32'd0);
    chk("single_hs_in_ready", {31'd0, i8.in_ready},  32'd1);
    chk("single_not_consumed", {24'd0, i8.out_min},  32'hA5);
    drive(1'b0, 8'h00, 1'b0);

    // Backpressure: frame 1,2 then out_ready low for 4 cycles while a beat is offered
    set_ordy(1'b0);
    beat(8'd1, 1'b0);
    beat(8'd2, 1'b1);
    drive(1'b1, 8'hEE, 1'b1);
    for (int c = 0; c < 4; c++) begin
      chk_res("bp", 8'd1, 8'd0, 8'd2, 8'd1, 8'd2);
      chk("bp_in_ready", {31'd0, i8.in_ready}, 32'd0);
      tick();
    end
    set_ordy(1'b1);
    chk("bp_before_hs_valid", {31'd0, i8.out_valid}, 32'd1);
    tick();
    chk("bp_after_hs_valid", {31'd0, i8.out_valid}, 32'd0);
    set_ordy(1'b0);
    beat(8'hEE, 1'b1);
    chk_res("bp_next", 8'hEE, 8'd0, 8'hEE, 8'd0, 8'd1);
    set_ordy(1'b1);
    tick();
    set_ordy(1'b0);

    // Saturating count on the CNT_W=2 instance; CNT_W=8 shows unsaturated indices
    beat(8'd7, 1'b0);
    beat(8'd6, 1'b0);
    beat(8'd5, 1'b0);
    beat(8'd4, 1'b0);
    beat(8'd3, 1'b0);
    beat(8'd2, 1'b1);
    chk("sat_valid",   {31'd0, i2.out_valid},  32'd1);
    chk("sat_count",   {30'd0, i2.out_count},  32'd3);
    chk("sat_min",     {24'd0, i2.out_min},    32'd2);
    chk("sat_min_idx", {30'd0, i2.out_min_idx}, 32'd3);
    chk("sat_max",     {24'd0, i2.out_max},    32'd7);
    chk("sat_max_idx", {30'd0, i2.out_max_idx}, 32'd0);
    chk_res("wide6", 8'd2, 8'd5, 8'd7, 8'd0, 8'd6);
    set_ordy(1'b1);
    tick();
    set_ordy(1'b0);

    // Reset mid-frame discards the partial frame
    beat(8'd8, 1'b0);
    beat(8'd1, 1'b0);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_valid",   {31'd0, i8.out_valid},   32'd0);
    chk("mid_rst_min",     {24'd0, i8.out_min},     32'd0);
    chk("mid_rst_max",     {24'd0, i8.out_max},     32'd0);
    chk("mid_rst_min_idx", {24'd0, i8.out_min_idx}, 32'd0);
    chk("mid_rst_max_idx", {24'd0, i8.out_max_idx}, 32'd0);
    chk("mid_rst_count",   {24'd0, i8.out_count},   32'd0);
    rst_n = 1'b1;
    tick();
    beat(8'd4, 1'b1);
    chk_res("post_rst", 8'd4, 8'd0, 8'd4, 8'd0, 8'd1);
    set_ordy(1'b1);
    tick();
    set_ordy(1'b0);

    // Sign-sensitive ordering
    beat(8'h7F, 1'b0);
    beat(8'h80, 1'b0);
    beat(8'h00, 1'b1);
`ifdef MINMAX_SIGNED_EN
    chk_res("order", 8'h80, 8'd1, 8'h7F, 8'd0, 8'd3);
`else
    chk_res("order", 8'h00, 8'd2, 8'h80, 8'd1, 8'd3);
`endif
    set_ordy(1'b1);
    tick();
    chk("order_hs_valid", {31'd0, i8.out_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
